// File: rtl/hex_word_streamer.sv
// Streams a WIDTH-bit word as ASCII hex characters, most significant nibble first, plus an optional CR/LF.
// First character is valid one cycle after acceptance; a stalled sink holds out_char and the state until out_ready.
module hex_word_streamer #(
   parameter int WIDTH     = 16,
   parameter int UPPERCASE = 0,
   parameter int TERMINATE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [7:0]       out_char,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DIGIT = 2'd1,
      CR    = 2'd2,
      LF    = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic [7:0]       char_q, char_d;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      logic [7:0] code;
      if (n < 4'd10) begin
         code = 8'h30 + {4'h0, n};
      end else if (UPPERCASE != 0) begin
         code = 8'h41 + {4'h0, n} - 8'd10;
      end else begin
         code = 8'h61 + {4'h0, n} - 8'd10;
      end
      return code;
   endfunction

   function automatic logic [3:0] nibble_at(input logic [WIDTH-1:0] word, input logic [IDXW-1:0] idx);
      logic [WIDTH-1:0] shifted;
      shifted = word >> {idx, 2'b00};
      return shifted[3:0];
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         word_q  <= '0;
         idx_q   <= '0;
         char_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
         char_q  <= char_d;
      end
   end

   // The next character is computed a cycle early so out_char comes straight from a register.
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      idx_d   = idx_q;
      char_d  = char_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = DIGIT;
               word_d  = in_data;
               idx_d   = LAST_IDX;
               char_d  = hex_char(nibble_at(in_data, LAST_IDX));
            end
         end
         DIGIT: begin
            if (out_ready) begin
               if (idx_q != '0) begin
                  idx_d  = idx_q - 1'b1;
                  char_d = hex_char(nibble_at(word_q, idx_q - 1'b1));
               end else if (TERMINATE == 2) begin
                  state_d = CR;
                  char_d  = 8'h0d;
               end else if (TERMINATE == 1) begin
                  state_d = LF;
                  char_d  = 8'h0a;
               end else begin
                  state_d = IDLE;
                  char_d  = 8'h00;
               end
            end
         end
         CR: begin
            if (out_ready) begin
               state_d = LF;
               char_d  = 8'h0a;
            end
         end
         LF: begin
            if (out_ready) begin
               state_d = IDLE;
               char_d  = 8'h00;
            end
         end
         default: begin
            state_d = IDLE;
            char_d  = 8'h00;
         end
      endcase
   end

   assign out_char  = char_q;
   assign out_valid = (state_q != IDLE);
   assign busy      = out_valid;
   assign in_ready  = (state_q == IDLE);

endmodule

// File: tb/tb_hex_word_streamer.sv
// Bench for hex_word_streamer: three configurations side by side, directed cases then randomized traffic.
module tb_hex_word_streamer;

   localparam int W [3] = '{16, 16, 8};
   localparam int U [3] = '{0, 1, 0};
   localparam int T [3] = '{1, 2, 0};

   logic             clk = 1'b0;
   logic             rst;
   logic [2:0][15:0] din;
   logic [2:0]       ival, irdy, ov, ordy, bsy;
   logic [2:0][7:0]  oc;

   int passed = 0;
   int total  = 0;

   logic [7:0] capq [3][$];
   logic [7:0] expq [3][$];

   always #5 clk = ~clk;

   hex_word_streamer #(.WIDTH(16), .UPPERCASE(0), .TERMINATE(1)) dut0 (
      .clk(clk), .rst(rst), .in_data(din[0]), .in_valid(ival[0]), .in_ready(irdy[0]),
      .out_char(oc[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .busy(bsy[0]));

   hex_word_streamer #(.WIDTH(16), .UPPERCASE(1), .TERMINATE(2)) dut1 (
      .clk(clk), .rst(rst), .in_data(din[1]), .in_valid(ival[1]), .in_ready(irdy[1]),
      .out_char(oc[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .busy(bsy[1]));

   hex_word_streamer #(.WIDTH(8), .UPPERCASE(0), .TERMINATE(0)) dut2 (
      .clk(clk), .rst(rst), .in_data(din[2][7:0]), .in_valid(ival[2]), .in_ready(irdy[2]),
      .out_char(oc[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .busy(bsy[2]));

   // Transfers are recorded half a cycle before the edge that completes them.
   always @(negedge clk) begin
      if (!rst) begin
         for (int k = 0; k < 3; k++) begin
            if (ov[k] && ordy[k]) capq[k].push_back(oc[k]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Expected character string for one word, built from the hex text rules.
   function automatic int model(input int k, input logic [15:0] w, output logic [7:0] e [8]);
      int n;
      int nib;
      n = 0;
      for (int i = 0; i < 8; i++) e[i] = 8'h00;
      for (int i = W[k] / 4 - 1; i >= 0; i--) begin
         nib = int'((w >> (4 * i)) & 16'h000f);
         e[n] = (nib < 10) ? 8'(48 + nib) : 8'(((U[k] != 0) ? 65 : 97) + nib - 10);
         n++;
      end
      if (T[k] == 2) begin
         e[n] = 8'h0d;
         n++;
      end
      if (T[k] >= 1) begin
         e[n] = 8'h0a;
         n++;
      end
      return n;
   endfunction

   task automatic push_exp(input int k, input logic [15:0] w);
      logic [7:0] e [8];
      int n;
      n = model(k, w, e);
      for (int i = 0; i < n; i++) expq[k].push_back(e[i]);
   endtask

   task automatic run_word(input int k, input logic [15:0] w, input int stall_at, input int stall_len);
      logic [7:0] e [8];
      int n;
      n = model(k, w, e);
      din[k]  = w;
      ival[k] = 1'b1;
      ordy[k] = 1'b1;
      chk($sformatf("d%0d_accept_rdy", k), irdy[k], 1);
      tick();
      ival[k] = 1'b0;
      din[k]  = 16'h5a5a;
      for (int i = 0; i < n; i++) begin
         if (i == stall_at) begin
            ordy[k] = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
               chk($sformatf("d%0d_stall_char%0d", k, s), oc[k], e[i]);
               chk($sformatf("d%0d_stall_vld%0d", k, s), ov[k], 1);
               tick();
            end
            ordy[k] = 1'b1;
         end
         chk($sformatf("d%0d_char%0d", k, i), oc[k], e[i]);
         chk($sformatf("d%0d_vld%0d", k, i), ov[k], 1);
         chk($sformatf("d%0d_busy%0d", k, i), bsy[k], 1);
         chk($sformatf("d%0d_inrdy_busy%0d", k, i), irdy[k], 0);
         tick();
      end
      chk($sformatf("d%0d_end_vld", k), ov[k], 0);
      chk($sformatf("d%0d_end_inrdy", k), irdy[k], 1);
      chk($sformatf("d%0d_end_busy", k), bsy[k], 0);
   endtask

   initial begin
      logic [7:0] e0 [8];
      logic [7:0] e1 [8];
      int n0, n1, accepted, cyc, acc2_cyc;
      int sent [3];
      logic [2:0] acc_now, stall_prev;
      logic [2:0][7:0] char_prev;
      localparam int NW = 40;

      rst  = 1'b1;
      ival = 3'b111;
      ordy = 3'b000;
      din  = '0;

      // Reset held two cycles with in_valid high
      tick();
      tick();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_vld%0d", k), ov[k], 0);
         chk($sformatf("rst_inrdy%0d", k), irdy[k], 1);
         chk($sformatf("rst_busy%0d", k), bsy[k], 0);
         chk($sformatf("rst_char%0d", k), oc[k], 8'h00);
      end
      ival = 3'b000;
      rst  = 1'b0;
      tick();
      chk("post_rst_idle", ov, 3'b000);

      // Plain word, then the same word with a 3-cycle stall on the second character
      run_word(0, 16'h3af0, -1, 0);
      run_word(0, 16'h3af0, 1, 3);
      // Uppercase with CR LF
      run_word(1, 16'hbeef, -1, 0);

      // Back-to-back words with in_valid held high, no terminator
      capq[2].delete();
      n0 = model(2, 16'h0009, e0);
      n1 = model(2, 16'h00ff, e1);
      din[2]  = 16'h0009;
      ival[2] = 1'b1;
      ordy[2] = 1'b1;
      accepted = 0;
      acc2_cyc = -1;
      cyc = 0;
      while (accepted < 2 && cyc < 50) begin
         if (irdy[2]) begin
            accepted++;
            if (accepted == 2) acc2_cyc = cyc;
            tick();
            if (accepted == 1) din[2] = 16'h00ff;
            else ival[2] = 1'b0;
         end else begin
            tick();
         end
         cyc++;
      end
      chk("b2b_accepts", accepted, 2);
      chk("b2b_period", acc2_cyc, n0 + 1);
      cyc = 0;
      while (ov[2] && cyc < 50) begin
         tick();
         cyc++;
      end
      chk("b2b_drain", ov[2], 0);
      chk("b2b_count", capq[2].size(), n0 + n1);
      for (int i = 0; i < n0 + n1; i++) begin
         if (i < capq[2].size())
            chk($sformatf("b2b_char%0d", i), capq[2][i], (i < n0) ? e0[i] : e1[i - n0]);
         else
            chk($sformatf("b2b_char%0d_missing", i), 0, 1);
      end

      // Reset in the middle of a word, then a clean word
      n0 = model(0, 16'h1234, e0);
      din[0]  = 16'h1234;
      ival[0] = 1'b1;
      ordy[0] = 1'b1;
      tick();
      ival[0] = 1'b0;
      chk("abort_char0", oc[0], e0[0]);
      tick();
      chk("abort_char1", oc[0], e0[1]);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_vld", ov[0], 0);
      chk("abort_char", oc[0], 8'h00);
      chk("abort_inrdy", irdy[0], 1);
      chk("abort_busy", bsy[0], 0);
      tick();
      chk("abort_no_resume", ov[0], 0);
      run_word(0, 16'h00ff, -1, 0);

      // Randomized traffic on all three instances against the character model
      for (int k = 0; k < 3; k++) begin
         capq[k].delete();
         expq[k].delete();
         sent[k] = 0;
      end
      stall_prev = 3'b000;
      char_prev  = '0;
      cyc = 0;
      while (cyc < 6000 && !(sent[0] == NW && sent[1] == NW && sent[2] == NW && ov == 3'b000)) begin
         acc_now = 3'b000;
         for (int k = 0; k < 3; k++) begin
            if (stall_prev[k]) begin
               chk($sformatf("rnd_hold_char%0d", k), oc[k], char_prev[k]);
               chk($sformatf("rnd_hold_vld%0d", k), ov[k], 1);
            end
            chk($sformatf("rnd_busy%0d", k), bsy[k], ov[k]);
            chk($sformatf("rnd_inrdy%0d", k), irdy[k], !ov[k]);
            ordy[k] = ($urandom_range(0, 3) != 0);
            if (!ival[k]) begin
               din[k] = 16'($urandom);
               if (sent[k] < NW && $urandom_range(0, 2) == 0) ival[k] = 1'b1;
            end
            if (ival[k] && irdy[k]) begin
               push_exp(k, din[k]);
               acc_now[k] = 1'b1;
            end
            stall_prev[k] = ov[k] && !ordy[k];
            char_prev[k]  = oc[k];
         end
         tick();
         for (int k = 0; k < 3; k++) begin
            if (acc_now[k]) begin
               ival[k] = 1'b0;
               sent[k]++;
            end
         end
         cyc++;
      end
      chk("rnd_finished", cyc < 6000, 1);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rnd_words%0d", k), sent[k], NW);
         chk($sformatf("rnd_len%0d", k), capq[k].size(), expq[k].size());
         for (int i = 0; i < expq[k].size(); i++) begin
            if (i < capq[k].size())
               chk($sformatf("rnd_d%0d_char%0d", k, i), capq[k][i], expq[k][i]);
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
